// File: rtl/avst_fifo_pkg.sv
// Shared types, constants and elaboration-time helpers for the Avalon-ST packet FIFO.
// A stored beat is laid out as {sop, eop, data}.
package avst_fifo_pkg;

  localparam int BEAT_SIDEBAND_W = 32'sd2;

  typedef struct packed {
    logic sop;
    logic eop;
  } beat_flags_t;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  function automatic int beat_width(input int data_width);
    return data_width + BEAT_SIDEBAND_W;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
  endfunction

  function automatic bit params_legal(input int data_width, input int depth,
                                      input int addr_width, input int almost_full,
                                      input int almost_empty, input int store_fwd);
    return (data_width >= 32'sd1) &&
           (depth >= 32'sd4) && is_pow2(depth) &&
           (clog2(depth) == addr_width) &&
           (almost_full >= 32'sd1) && (almost_full <= depth) &&
           (almost_empty >= 32'sd0) && (almost_empty <= depth - 32'sd1) &&
           ((store_fwd == 32'sd0) || (store_fwd == 32'sd1));
  endfunction

endpackage

// File: rtl/avst_fifo_ram.sv
// Simple dual-port memory with a registered read port; the read register doubles
// as the FIFO output stage, so it carries an asynchronous reset to zero.
module avst_fifo_ram #(
  parameter int WIDTH      = 44,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/avst_pkt_fifo.sv
// Parametrised Avalon-ST single-clock FIFO with sop/eop sideband, fill-level status,
// synchronous flush and optional store-and-forward packet release.
module avst_pkt_fifo
  import avst_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 42,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int ALMOST_FULL  = 12,
  parameter int ALMOST_EMPTY = 2,
  parameter int STORE_FWD    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  oversize_err
);

  localparam int BEAT_W = beat_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LVL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_LVL    = (ADDR_WIDTH + 1)'(ALMOST_FULL);
  localparam logic [ADDR_WIDTH:0]   AE_LVL    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

  if (!params_legal(DATA_WIDTH, DEPTH, ADDR_WIDTH, ALMOST_FULL, ALMOST_EMPTY, STORE_FWD)) begin : g_param_err
    $error("avst_pkt_fifo: illegal parameter combination");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   fill_r;
  logic [ADDR_WIDTH:0]   pkt_cnt_r;
  logic                  full_r;
  logic                  out_valid_r;
  logic                  force_fwd_r;
  logic                  oversize_err_r;

  logic [ADDR_WIDTH:0]   fill_next_s;
  logic [ADDR_WIDTH:0]   pkt_cnt_next_s;
  logic [ADDR_WIDTH:0]   mem_cnt_s;
  logic                  wr_s;
  logic                  rd_s;
  logic                  wr_eop_s;
  logic                  rd_eop_s;
  logic                  held_eop_s;
  logic                  pkt_avail_s;
  logic                  set_force_s;
  logic                  load_s;
  logic [BEAT_W-1:0]     wr_beat_s;
  logic [BEAT_W-1:0]     rd_beat_s;
  beat_flags_t           rd_flags_s;

  assign wr_beat_s  = {in_sop, in_eop, in_data};
  assign rd_flags_s = rd_beat_s[BEAT_W-1 -: BEAT_SIDEBAND_W];

  // Handshake qualification, head-release decision and next-state arithmetic.
  always_comb begin
    wr_s       = in_valid && !full_r && !clear;
    rd_s       = out_valid_r && out_ready && !clear;
    wr_eop_s   = wr_s && in_eop;
    rd_eop_s   = rd_s && rd_flags_s.eop;
    held_eop_s = out_valid_r && rd_flags_s.eop;
    // Words still in the array, i.e. not yet moved into the output register.
    mem_cnt_s  = fill_r - {{ADDR_WIDTH{1'b0}}, out_valid_r};
    if (STORE_FWD != 32'sd0) begin
      // A complete packet must lie beyond any EOP already sitting in the output register.
      pkt_avail_s = (force_fwd_r && !held_eop_s) ||
                    (pkt_cnt_r > {{ADDR_WIDTH{1'b0}}, held_eop_s});
      set_force_s = full_r && !force_fwd_r && (pkt_cnt_r == '0) && !clear;
    end else begin
      pkt_avail_s = 1'b1;
      set_force_s = 1'b0;
    end
    load_s = (mem_cnt_s != '0) && (!out_valid_r || out_ready) && pkt_avail_s && !clear;
    case ({wr_s, rd_s})
      2'b10:   fill_next_s = fill_r + LVL_ONE;
      2'b01:   fill_next_s = fill_r - LVL_ONE;
      default: fill_next_s = fill_r;
    endcase
    case ({wr_eop_s, rd_eop_s})
      2'b10:   pkt_cnt_next_s = pkt_cnt_r + LVL_ONE;
      2'b01:   pkt_cnt_next_s = pkt_cnt_r - LVL_ONE;
      default: pkt_cnt_next_s = pkt_cnt_r;
    endcase
  end

  // Pointers, level/packet counters, output-valid and store-and-forward state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      fill_r         <= '0;
      pkt_cnt_r      <= '0;
      full_r         <= 1'b0;
      out_valid_r    <= 1'b0;
      force_fwd_r    <= 1'b0;
      oversize_err_r <= 1'b0;
    end else if (clear) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      fill_r         <= '0;
      pkt_cnt_r      <= '0;
      full_r         <= 1'b0;
      out_valid_r    <= 1'b0;
      force_fwd_r    <= 1'b0;
      oversize_err_r <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      fill_r    <= fill_next_s;
      full_r    <= (fill_next_s == DEPTH_LVL);
      pkt_cnt_r <= pkt_cnt_next_s;
      if (load_s) begin
        out_valid_r <= 1'b1;
      end else if (rd_s) begin
        out_valid_r <= 1'b0;
      end
      if (set_force_s) begin
        force_fwd_r <= 1'b1;
      end else if (rd_eop_s) begin
        force_fwd_r <= 1'b0;
      end
      if (set_force_s) begin
        oversize_err_r <= 1'b1;
      end
    end
  end

  avst_fifo_ram #(
    .WIDTH      (BEAT_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_beat_s),
    .rd_en   (load_s),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_beat_s)
  );

  assign in_ready     = !full_r;
  assign out_valid    = out_valid_r;
  assign out_data     = rd_beat_s[DATA_WIDTH-1:0];
  assign out_sop      = rd_flags_s.sop;
  assign out_eop      = rd_flags_s.eop;
  assign fill_level   = fill_r;
  assign almost_full  = (fill_r >= AF_LVL);
  assign almost_empty = (fill_r <= AE_LVL);
  assign oversize_err = oversize_err_r;

endmodule

// File: tb/tb_avst_pkt_fifo.sv
// Directed bench for avst_pkt_fifo: one cut-through and one store-and-forward instance
// driven from a single linear sequence of steps.
module tb_avst_pkt_fifo;

  localparam int DW = 42;

  logic clk;
  logic reset_n;

  logic          c_clear, c_in_ready, c_in_valid, c_in_sop, c_in_eop;
  logic [DW-1:0] c_in_data, c_out_data;
  logic          c_out_ready, c_out_valid, c_out_sop, c_out_eop;
  logic [4:0]    c_fill_level;
  logic          c_almost_full, c_almost_empty, c_oversize_err;

  logic          s_clear, s_in_ready, s_in_valid, s_in_sop, s_in_eop;
  logic [DW-1:0] s_in_data, s_out_data;
  logic          s_out_ready, s_out_valid, s_out_sop, s_out_eop;
  logic [4:0]    s_fill_level;
  logic          s_almost_full, s_almost_empty, s_oversize_err;

  int n_checks;
  int n_fail;

  avst_pkt_fifo #(
    .DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(4),
    .ALMOST_FULL(12), .ALMOST_EMPTY(2), .STORE_FWD(0)
  ) u_ct (
    .clk(clk), .reset_n(reset_n), .clear(c_clear),
    .in_ready(c_in_ready), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_sop(c_in_sop), .in_eop(c_in_eop),
    .out_ready(c_out_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_sop(c_out_sop), .out_eop(c_out_eop),
    .fill_level(c_fill_level), .almost_full(c_almost_full),
    .almost_empty(c_almost_empty), .oversize_err(c_oversize_err)
  );

  avst_pkt_fifo #(
    .DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(4),
    .ALMOST_FULL(12), .ALMOST_EMPTY(2), .STORE_FWD(1)
  ) u_sf (
    .clk(clk), .reset_n(reset_n), .clear(s_clear),
    .in_ready(s_in_ready), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_sop(s_in_sop), .in_eop(s_in_eop),
    .out_ready(s_out_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_sop(s_out_sop), .out_eop(s_out_eop),
    .fill_level(s_fill_level), .almost_full(s_almost_full),
    .almost_empty(s_almost_empty), .oversize_err(s_oversize_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] next_data;
    int            model_fill;
    int            n;
    int            m;
    bit            wr;
    bit            rd;
    int unsigned   seed_val;

    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    c_clear = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_in_sop = 1'b0; c_in_eop = 1'b0; c_out_ready = 1'b0;
    s_clear = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_in_sop = 1'b0; s_in_eop = 1'b0; s_out_ready = 1'b0;

    // Reset state, observed while reset is held.
    #12;
    check("rst_out_valid", c_out_valid, 1'b0);
    check("rst_out_data", c_out_data, '0);
    check("rst_fill", c_fill_level, 5'd0);
    check("rst_in_ready", c_in_ready, 1'b1);
    check("rst_sf_oversize", s_oversize_err, 1'b0);
    check("rst_sf_out_valid", s_out_valid, 1'b0);
    reset_n = 1'b1;
    step();
    check("post_rst_in_ready", c_in_ready, 1'b1);

    // Single word, two-cycle latency from acceptance.
    c_in_valid = 1'b1; c_in_data = 42'h1; c_in_sop = 1'b1; c_in_eop = 1'b1;
    step();
    c_in_valid = 1'b0; c_in_sop = 1'b0; c_in_eop = 1'b0;
    check("lat_c1_valid", c_out_valid, 1'b0);
    check("lat_c1_fill", c_fill_level, 5'd1);
    step();
    check("lat_c2_valid", c_out_valid, 1'b1);
    check("lat_c2_data", c_out_data, 42'h1);
    check("lat_c2_sop", c_out_sop, 1'b1);
    check("lat_c2_eop", c_out_eop, 1'b1);
    check("lat_c2_fill", c_fill_level, 5'd1);
    check("lat_c2_ae", c_almost_empty, 1'b1);
    check("lat_c2_af", c_almost_full, 1'b0);
    c_out_ready = 1'b1;
    step();
    c_out_ready = 1'b0;
    check("single_drain_valid", c_out_valid, 1'b0);
    check("single_drain_fill", c_fill_level, 5'd0);

    // Fill to DEPTH without reads; a beat offered while full must be refused.
    for (int i = 0; i < 16; i++) begin
      check("fill_in_ready", c_in_ready, 1'b1);
      c_in_valid = 1'b1;
      c_in_data  = DW'(32'h100 + i);
      step();
      check("fill_level", c_fill_level, 64'(i + 1));
      check("fill_af", c_almost_full, (i + 1) >= 12);
    end
    c_in_data = 42'hBAD;
    check("full_in_ready", c_in_ready, 1'b0);
    step();
    c_in_valid = 1'b0;
    check("full_fill", c_fill_level, 5'd16);
    check("full_ae", c_almost_empty, 1'b0);
    check("ct_no_oversize", c_oversize_err, 1'b0);
    c_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", c_out_valid, 1'b1);
      check("drain_data", c_out_data, 64'(32'h100 + i));
      step();
    end
    c_out_ready = 1'b0;
    check("drain_end_valid", c_out_valid, 1'b0);
    check("drain_end_fill", c_fill_level, 5'd0);
    check("drain_end_ready", c_in_ready, 1'b1);

    // Random handshakes against an in-order scoreboard, through many pointer wraps.
    seed_val   = $urandom(32'd20240611);
    model_fill = 0;
    next_data  = 42'h2000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("rnd_fill", c_fill_level, 64'(model_fill));
      check("rnd_in_ready", c_in_ready, model_fill != 16);
      c_in_valid  = ($urandom_range(0, 99) < 60);
      c_out_ready = ($urandom_range(0, 99) < 55);
      c_in_data   = next_data;
      wr = c_in_valid && c_in_ready;
      rd = c_out_valid && c_out_ready;
      if (rd) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious_valid", c_out_valid, 1'b0);
        end else begin
          check("rnd_data", c_out_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      if (wr) begin
        exp_q.push_back(next_data);
        next_data = next_data + 42'h1;
      end
      model_fill = model_fill + int'(wr) - int'(rd);
      step();
    end
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      if (c_out_valid) begin
        check("rnd_drain_data", c_out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      step();
    end
    c_out_ready = 1'b0;
    check("rnd_drain_empty", 64'(exp_q.size()), 64'd0);
    check("rnd_drain_fill", c_fill_level, 5'd0);

    // Store-and-forward: nothing is released until the EOP has been written.
    s_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = DW'(32'h200 + i);
      s_in_sop   = (i == 0);
      s_in_eop   = (i == 4);
      step();
      check("sf_hold_valid", s_out_valid, 1'b0);
    end
    s_in_valid = 1'b0; s_in_sop = 1'b0; s_in_eop = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("sf_pkt_valid", s_out_valid, 1'b1);
      check("sf_pkt_data", s_out_data, 64'(32'h200 + i));
      check("sf_pkt_sop", s_out_sop, i == 0);
      check("sf_pkt_eop", s_out_eop, i == 4);
      step();
    end
    check("sf_pkt_end_valid", s_out_valid, 1'b0);
    check("sf_pkt_end_fill", s_fill_level, 5'd0);
    check("sf_pkt_ae", s_almost_empty, 1'b1);
    check("sf_pkt_af", s_almost_full, 1'b0);
    check("sf_pkt_no_oversize", s_oversize_err, 1'b0);

    // Store-and-forward: a 20-word packet overflows, forces release, and still arrives intact.
    n = 0;
    m = 0;
    for (int cyc = 0; cyc < 200 && m < 20; cyc++) begin
      s_in_valid = (n < 20);
      s_in_data  = DW'(32'h300 + n);
      s_in_sop   = (n == 0);
      s_in_eop   = (n == 19);
      if (s_out_valid) begin
        if (m == 0) begin
          check("ovs_err_at_release", s_oversize_err, 1'b1);
          check("ovs_words_before_release", 64'(n), 64'd16);
        end
        check("ovs_data", s_out_data, 64'(32'h300 + m));
        check("ovs_sop", s_out_sop, m == 0);
        check("ovs_eop", s_out_eop, m == 19);
        m++;
      end
      wr = s_in_valid && s_in_ready;
      step();
      if (wr) begin
        n++;
      end
    end
    s_in_valid = 1'b0; s_in_sop = 1'b0; s_in_eop = 1'b0;
    check("ovs_all_delivered", 64'(m), 64'd20);
    check("ovs_end_valid", s_out_valid, 1'b0);
    check("ovs_sticky", s_oversize_err, 1'b1);
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    check("ovs_cleared", s_oversize_err, 1'b0);

    // Flush with 8 words held and a beat offered in the same cycle.
    for (int i = 0; i < 8; i++) begin
      c_in_valid = 1'b1;
      c_in_data  = DW'(32'h400 + i);
      step();
    end
    check("clr_pre_fill", c_fill_level, 5'd8);
    c_in_data = 42'hDEAD;
    c_clear   = 1'b1;
    step();
    c_clear    = 1'b0;
    c_in_valid = 1'b0;
    check("clr_fill", c_fill_level, 5'd0);
    check("clr_out_valid", c_out_valid, 1'b0);
    check("clr_in_ready", c_in_ready, 1'b1);
    c_in_valid = 1'b1;
    c_in_data  = 42'h500;
    step();
    c_in_valid = 1'b0;
    step();
    check("clr_next_valid", c_out_valid, 1'b1);
    check("clr_next_data", c_out_data, 42'h500);
    check("clr_next_fill", c_fill_level, 5'd1);
    c_out_ready = 1'b1;
    step();
    step();
    c_out_ready = 1'b0;
    check("clr_no_dropped_beat", c_out_valid, 1'b0);
    check("clr_final_fill", c_fill_level, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avst_pkt_fifo.md
Name: avst_pkt_fifo

Overview:
- Parametrised Avalon-ST single-clock FIFO that succeeds the fixed 42-bit/16-deep timing-adapter FIFO.
- Carries data plus startofpacket/endofpacket sideband.
- Reports fill level, almost-full and almost-empty status, and supports a synchronous flush.
- Optional store-and-forward mode: a packet is only presented downstream once its EOP has been written. Used between bursty packet sources and sinks that must not see mid-packet bubbles.

Parameters:
- DATA_WIDTH, 42, payload width in bits (>=1).
- DEPTH, 16, storage words; power of two, >=4.
- ADDR_WIDTH, 4, log2(DEPTH); must be consistent with DEPTH.
- ALMOST_FULL, 12, almost_full asserts when fill_level >= this value (1..DEPTH).
- ALMOST_EMPTY, 2, almost_empty asserts when fill_level <= this value (0..DEPTH-1).
- STORE_FWD, 0, 0 = cut-through; 1 = store-and-forward.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, active high.
- in_ready  out  1  FIFO can accept a word this cycle.
- in_valid  in  1  source word valid.
- in_data  in  DATA_WIDTH  payload.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- out_ready  in  1  sink accepts.
- out_valid  out  1  output word valid.
- out_data  out  DATA_WIDTH  payload.
- out_sop  out  1  start of packet.
- out_eop  out  1  end of packet.
- fill_level  out  ADDR_WIDTH+1  words held (0..DEPTH).
- almost_full  out  1  fill_level >= ALMOST_FULL.
- almost_empty  out  1  fill_level <= ALMOST_EMPTY.
- oversize_err  out  1  sticky: store-and-forward packet exceeded DEPTH.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers and counters = 0; empty.
  - out_valid = 0; out_data/out_sop/out_eop = 0; oversize_err = 0.
  - in_ready is 1 immediately after reset deasserts.
- Transfers: an input beat transfers when in_valid & in_ready; an output beat transfers when out_valid & out_ready. in_ready = !full, where full is a register. in_ready has no combinational path from in_valid, and does not depend on out_ready.
- Latency:
  - A word accepted in cycle c is first presented (out_valid=1) in cycle c+2 if the FIFO was empty.
  - Output is registered: out_data, out_sop and out_eop come from a register stage.
  - The register is reloaded with the next word in the same edge as a read, so back-to-back reads sustain 1 word/clk.
- fill_level:
  - Equals accepted minus delivered words; updated on the edge after the transfer.
  - Simultaneous write and read leaves it unchanged.
  - full is asserted at DEPTH; empty at 0.
  - almost_full/almost_empty are combinational compares on fill_level.
- Wrap-around: pointers are ADDR_WIDTH bits and wrap naturally. Full/empty are tracked by flags, not pointer compare, so all DEPTH entries are usable.
- Simultaneous read and write at full: not possible, since in_ready=0. At empty: the write proceeds; the read does not occur because out_valid=0.
- Store-and-forward (STORE_FWD=1):
  - pkt_cnt counts EOP words written minus EOP words read.
  - out_valid is additionally qualified by pkt_cnt>0, or by force_fwd.
  - If full && pkt_cnt==0, set oversize_err (sticky) and set force_fwd, which releases the head in cut-through fashion until the next EOP is read; force_fwd then clears.
  - pkt_cnt width is ADDR_WIDTH+1. A write with EOP and a read with EOP in the same edge leave pkt_cnt unchanged.
- Cut-through (STORE_FWD=0): pkt_cnt is ignored; sop/eop are stored and forwarded verbatim. No packet-framing checks are made.
- clear:
  - Takes effect at the next edge and has priority over any transfer in that cycle; the input beat is dropped.
  - Resets pointers, flags, fill_level, pkt_cnt, force_fwd and out_valid.
  - oversize_err is also cleared.
  - Memory contents are not cleared.
- Asynchronous reset mid-packet: all state is discarded; there is no partial-packet recovery.

Decomposition:
- Shared package avst_fifo_pkg:
  - clog2 function.
  - Beat struct typedef {sop, eop, data} width constant.
  - Parameter legality checks (DEPTH power of two, thresholds in range).
- One natural sub-module: avst_fifo_ram, a simple dual-port DEPTH x (DATA_WIDTH+2) registered-read memory, inferred as block RAM. Control, counters and store-and-forward logic remain in avst_pkt_fifo.

Test Plan:
- Reset, then write 1 word (data 0x1) with out_ready=0 -> out_valid=1 two cycles after acceptance; out_data=0x1; fill_level=1; almost_empty=1.
- Write 16 words with no reads (defaults) -> in_ready=0 after the 16th; fill_level=16; almost_full=1 from the 12th word. Then read continuously -> 16 words in order, 1/clk, out_valid drops after the last; fill_level=0.
- Random in_valid/out_ready (seeded, 400 cycles) with an incrementing data source -> scoreboard matches in order; fill_level always equals the model; no beat is lost at pointer wrap.
- STORE_FWD=1: 5-word packet (sop on word 0, eop on word 4) with out_ready=1 -> out_valid stays 0 until 2 cycles after the eop beat is accepted, then 5 consecutive beats with correct sop/eop.
- STORE_FWD=1: 20-word packet with DEPTH=16 -> oversize_err=1 when full; words start flowing; all 20 delivered in order; oversize_err stays 1 until clear.
- 8 words in FIFO, pulse clear together with in_valid=1 -> next cycle fill_level=0, out_valid=0, in_ready=1; the dropped beat never appears at the output.
